// File: rtl/pwl_activation.sv
// Piecewise-linear sigmoid / tanh on signed fixed-point samples; slopes are pure shifts.
// Latency: 3 cycles from accept to out_valid, one sample per cycle when not stalled.
// Backpressure: all stages freeze while out_valid && !out_ready; in_ready drops in the same cycle.
module pwl_activation #(
    parameter int WIDTH = 32,   // signed two's-complement data width, needs WIDTH >= FRAC + 5
    parameter int FRAC  = 16    // fractional bits, needs FRAC >= 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    // Fixed-point constants, all scaled by 2^FRAC.
    localparam logic [WIDTH-1:0] LSB1    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1)  << FRAC;        // 1.0
    localparam logic [WIDTH-1:0] M_SAT   = WIDTH'(5)  << FRAC;        // 5.0
    localparam logic [WIDTH-1:0] M_HI    = WIDTH'(19) << (FRAC - 3);  // 2.375
    localparam logic [WIDTH-1:0] C_HI    = WIDTH'(27) << (FRAC - 5);  // 0.84375
    localparam logic [WIDTH-1:0] C_MID   = WIDTH'(5)  << (FRAC - 3);  // 0.625
    localparam logic [WIDTH-1:0] C_LO    = WIDTH'(1)  << (FRAC - 1);  // 0.5
    localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}}; // 2^(WIDTH-1)-1

    // Single advance enable shared by every stage: the pipe moves as a whole.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // Stage 1 state: sign, magnitude, function select.
    logic             s1_vld;
    logic             s1_sign;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_mag;

    // Stage 2 state: segment output y before sign folding.
    logic             s2_vld;
    logic             s2_sign;
    logic             s2_mode;
    logic             s2_sat;
    logic [WIDTH-1:0] s2_y;

    // Stage 1 combinational: |x| (or |2x| for tanh), clamped to the largest positive value.
    logic [WIDTH-1:0] x_abs;
    logic [WIDTH:0]   m_wide;
    logic [WIDTH-1:0] m_next;

    // Magnitude: x_abs is unsigned so the most-negative input maps to 2^(WIDTH-1) without wrap,
    // the extra bit of m_wide holds the doubled tanh magnitude, and anything above MAG_MAX clamps.
    always_comb begin
        x_abs  = in_data[WIDTH-1] ? ((~in_data) + LSB1) : in_data;
        m_wide = in_mode ? {x_abs, 1'b0} : {1'b0, x_abs};
        m_next = (m_wide > {1'b0, MAG_MAX}) ? MAG_MAX : m_wide[WIDTH-1:0];
    end

    // Stage 1 register: capture sign, magnitude and mode of the accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mode <= 1'b0;
            s1_mag  <= '0;
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_sign <= in_data[WIDTH-1];
            s1_mode <= in_mode;
            s1_mag  <= m_next;
        end
    end

    // Stage 2 combinational: four-segment approximation of sigmoid(m) for m >= 0.
    logic [WIDTH-1:0] seg_y;
    logic             seg_sat;

    // Segment select: each threshold compare uses >=, so a boundary value takes the upper
    // segment. Shifts truncate, which is the intended rounding.
    always_comb begin
        seg_y   = ONE;
        seg_sat = 1'b0;
        if (s1_mag >= M_SAT) begin
            seg_y   = ONE;
            seg_sat = 1'b1;
        end else if (s1_mag >= M_HI) begin
            seg_y = (s1_mag >> 5) + C_HI;
        end else if (s1_mag >= ONE) begin
            seg_y = (s1_mag >> 3) + C_MID;
        end else begin
            seg_y = (s1_mag >> 2) + C_LO;
        end
    end

    // Stage 2 register: hold segment result and carry sign/mode/sat alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_mode <= 1'b0;
            s2_sat  <= 1'b0;
            s2_y    <= '0;
        end else if (adv) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_mode <= s1_mode;
            s2_sat  <= seg_sat;
            s2_y    <= seg_y;
        end
    end

    // Stage 3 combinational: reflect for negative inputs, then rescale for tanh.
    logic [WIDTH-1:0] fold_r;
    logic [WIDTH-1:0] res;

    // Symmetry: sigmoid(-x) = 1 - sigmoid(x); tanh(x) = 2*sigmoid(2x) - 1, the 2x already
    // folded into the stage 1 magnitude. fold_r <= 1.0 so the doubling cannot overflow.
    always_comb begin
        fold_r = s2_sign ? (ONE - s2_y) : s2_y;
        res    = s2_mode ? ((fold_r << 1) - ONE) : fold_r;
    end

    // Stage 3 register: the output holding register; frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            out_data  <= res;
            out_sat   <= s2_sat;
        end
    end

endmodule
